// File: rtl/keycode_event_decoder_if.sv
// Event handshake between the keycode decoder (master) and its consumer (slave).
// Each event carries {player, press, action} and is accepted when evt_valid & evt_ready.
interface keycode_event_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_player;
  logic       evt_press;
  logic [2:0] evt_action;

  modport master (
    output evt_valid,
    output evt_player,
    output evt_press,
    output evt_action,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_player,
    input  evt_press,
    input  evt_action,
    output evt_ready
  );
endinterface

// File: rtl/keycode_event_decoder.sv
// Keycode event decoder: reads the HID keycode written by the NIOS PIO and filters out
// transient values. Accepted changes become release/press events, which are queued in a
// small show-ahead FIFO. The decoder also reports per-player held levels and a frame hold
// counter.
// Optional feature: define KEY_REPEAT_EN to push an auto-repeat press every REPEAT_FRAMES
// frames while a mapped key stays held.
module keycode_event_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [7:0]                     keycode,
  input  logic                           frame_clk,
  keycode_event_decoder_if.master        evt,
  output logic [4:0]                     p1_held,
  output logic [4:0]                     p2_held,
  output logic [7:0]                     hold_frames,
  output logic                           overflow
);

`ifdef KEY_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FcntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [FcntW-1:0] FcntMax = FcntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFilter, StEmitRel, StEmitPress} state_e;

  // Returns {mapped, player, action[2:0]}.
  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h04:   map_key = {1'b1, 1'b0, 3'd0};
      8'h07:   map_key = {1'b1, 1'b0, 3'd1};
      8'h1A:   map_key = {1'b1, 1'b0, 3'd2};
      8'h16:   map_key = {1'b1, 1'b0, 3'd3};
      8'h09:   map_key = {1'b1, 1'b0, 3'd4};
      8'h50:   map_key = {1'b1, 1'b1, 3'd0};
      8'h4F:   map_key = {1'b1, 1'b1, 3'd1};
      8'h52:   map_key = {1'b1, 1'b1, 3'd2};
      8'h51:   map_key = {1'b1, 1'b1, 3'd3};
      8'h0D:   map_key = {1'b1, 1'b1, 3'd4};
      default: map_key = 5'b0;
    endcase
  endfunction

  state_e          state_q;
  logic [7:0]      accepted_q, cand_q, old_q;
  logic [CntW-1:0] cnt_q;
  logic            frame_q;

  logic [4:0] acc_map, old_map;
  logic       frame_tick, repeat_hit;
  logic       push_req, push_ok, pop, full;
  logic [4:0] push_data;

  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0] fcnt_q;
  logic [4:0]       head;

  assign acc_map    = map_key(accepted_q);
  assign old_map    = map_key(old_q);
  assign frame_tick = frame_clk & ~frame_q;

  // Repeat fires on the tick that moves hold_frames onto a multiple of REPEAT_FRAMES.
  assign repeat_hit = RepeatEn && acc_map[4] && frame_tick && (hold_frames != 8'hFF) &&
                      (((32'(hold_frames) + 32'd1) % REPEAT_FRAMES) == 32'd0);

  // Event push request derived from the current FSM state.
  always_comb begin
    push_req  = 1'b0;
    push_data = 5'b0;
    unique case (state_q)
      StEmitRel: begin
        push_req  = old_map[4];
        push_data = {old_map[3], 1'b0, old_map[2:0]};
      end
      StEmitPress: begin
        push_req  = acc_map[4];
        push_data = {acc_map[3], 1'b1, acc_map[2:0]};
      end
      StIdle: begin
        push_req  = repeat_hit;
        push_data = {acc_map[3], 1'b1, acc_map[2:0]};
      end
      default: ;
    endcase
  end

  // Filter FSM, held levels, frame edge detector and hold counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      accepted_q  <= 8'h00;
      cand_q      <= 8'h00;
      old_q       <= 8'h00;
      cnt_q       <= '0;
      frame_q     <= frame_clk;
      p1_held     <= 5'b0;
      p2_held     <= 5'b0;
      hold_frames <= 8'h00;
    end else begin
      frame_q <= frame_clk;
      unique case (state_q)
        StIdle: begin
          if (keycode != accepted_q) begin
            state_q <= StFilter;
            cand_q  <= keycode;
            cnt_q   <= CntW'(1);
          end
        end
        StFilter: begin
          if (keycode == accepted_q) begin
            state_q <= StIdle;
          end else if (keycode == cand_q) begin
            if (cnt_q == CntLast) begin
              state_q    <= StEmitRel;
              old_q      <= accepted_q;
              accepted_q <= cand_q;
            end
            cnt_q <= cnt_q + CntW'(1);
          end else begin
            cand_q <= keycode;
            cnt_q  <= CntW'(1);
          end
        end
        StEmitRel: begin
          if (old_map[4]) begin
            if (old_map[3]) p2_held[old_map[2:0]] <= 1'b0;
            else            p1_held[old_map[2:0]] <= 1'b0;
          end
          state_q <= StEmitPress;
        end
        StEmitPress: begin
          if (acc_map[4]) begin
            if (acc_map[3]) p2_held[acc_map[2:0]] <= 1'b1;
            else            p1_held[acc_map[2:0]] <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // The clear on a new press beats a coincident frame tick.
      if (state_q == StEmitPress || !acc_map[4]) begin
        hold_frames <= 8'h00;
      end else if (frame_tick && hold_frames != 8'hFF) begin
        hold_frames <= hold_frames + 8'd1;
      end
    end
  end

  assign full = (fcnt_q == FcntMax);
  assign pop  = evt.evt_valid & evt.evt_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_req & (~full | pop);

  // Show-ahead event FIFO with sticky overflow flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fcnt_q <= fcnt_q + FcntW'(push_ok) - FcntW'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign evt.evt_valid  = (fcnt_q != '0);
  assign evt.evt_player = evt.evt_valid & head[4];
  assign evt.evt_press  = evt.evt_valid & head[3];
  assign evt.evt_action = evt.evt_valid ? head[2:0] : 3'd0;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Testbench for keycode_event_decoder: table-driven key transitions plus hand-written
// sequences for latency, glitch filtering, overflow, hold saturation and mid-emission reset.
module tb_keycode_event_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keycode;
  logic       frame_clk;
  logic [4:0] p1_held, p2_held;
  logic [7:0] hold_frames;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Events seen leaving the FIFO, encoded {player, press, action}.
  logic [4:0] evq[$];

  keycode_event_decoder_if evt_if ();

  keycode_event_decoder #(
    .STABLE_CYCLES(16),
    .FIFO_DEPTH   (4),
    .REPEAT_FRAMES(8)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .keycode    (keycode),
    .frame_clk  (frame_clk),
    .evt        (evt_if),
    .p1_held    (p1_held),
    .p2_held    (p2_held),
    .hold_frames(hold_frames),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Record handshakes mid-cycle; inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (!rst && evt_if.evt_valid && evt_if.evt_ready)
      evq.push_back({evt_if.evt_player, evt_if.evt_press, evt_if.evt_action});
  end

  typedef struct {
    logic [7:0] key;
    int         n_evt;
    logic [4:0] first_evt;
    logic [4:0] last_evt;
    logic [4:0] p1;
    logic [4:0] p2;
  } vec_t;

  vec_t vecs[13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " evt_valid"}, 32'(evt_if.evt_valid), 32'd0);
    check({tag, " evt_fields"},
          32'({evt_if.evt_player, evt_if.evt_press, evt_if.evt_action}), 32'd0);
    check({tag, " held"}, 32'({p1_held, p2_held}), 32'd0);
    check({tag, " hold_frames"}, 32'(hold_frames), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic frame_ticks(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      tick(1);
      frame_clk = 1'b0;
      tick(1);
    end
  endtask

  function automatic logic [4:0] head();
    return {evt_if.evt_player, evt_if.evt_press, evt_if.evt_action};
  endfunction

  initial begin
    int exp_hold_events;

    // {key, events, first, last, p1_held, p2_held}; starts with 0x04 accepted.
    vecs[0]  = '{8'h50, 2, 5'b00000, 5'b11000, 5'b00000, 5'b00001};
    vecs[1]  = '{8'h00, 1, 5'b10000, 5'b10000, 5'b00000, 5'b00000};
    vecs[2]  = '{8'h1A, 1, 5'b01010, 5'b01010, 5'b00100, 5'b00000};
    vecs[3]  = '{8'h33, 1, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    vecs[4]  = '{8'h34, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    vecs[5]  = '{8'h0D, 1, 5'b11100, 5'b11100, 5'b00000, 5'b10000};
    vecs[6]  = '{8'h16, 2, 5'b10100, 5'b01011, 5'b01000, 5'b00000};
    vecs[7]  = '{8'h09, 2, 5'b00011, 5'b01100, 5'b10000, 5'b00000};
    vecs[8]  = '{8'h4F, 2, 5'b00100, 5'b11001, 5'b00000, 5'b00010};
    vecs[9]  = '{8'h51, 2, 5'b10001, 5'b11011, 5'b00000, 5'b01000};
    vecs[10] = '{8'h52, 2, 5'b10011, 5'b11010, 5'b00000, 5'b00100};
    vecs[11] = '{8'h07, 2, 5'b10010, 5'b01001, 5'b00010, 5'b00000};
    vecs[12] = '{8'h00, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000};

    rst                = 1'b1;
    keycode            = 8'h00;
    frame_clk          = 1'b0;
    evt_if.evt_ready   = 1'b0;
    tick(3);
    check_reset("reset");
    rst = 1'b0;

    // Latency: first sampling edge is cycle 0, head valid after cycle 17.
    keycode = 8'h04;
    tick(17);
    check("lat valid@16", 32'(evt_if.evt_valid), 32'd0);
    tick(1);
    check("lat valid@17", 32'(evt_if.evt_valid), 32'd1);
    check("lat head", 32'(head()), 32'(5'b01000));
    check("lat p1_held", 32'(p1_held), 32'(5'b00001));
    evt_if.evt_ready = 1'b1;
    tick(3);
    check("lat drained", 32'(evt_if.evt_valid), 32'd0);

    for (int i = 0; i < 13; i++) begin
      evq.delete();
      keycode = vecs[i].key;
      tick(30);
      check($sformatf("vec%0d n_evt", i), 32'(evq.size()), 32'(vecs[i].n_evt));
      if (vecs[i].n_evt > 0) begin
        check($sformatf("vec%0d first", i), 32'(evq[0]), 32'(vecs[i].first_evt));
        check($sformatf("vec%0d last", i), 32'(evq[evq.size()-1]), 32'(vecs[i].last_evt));
      end
      check($sformatf("vec%0d p1_held", i), 32'(p1_held), 32'(vecs[i].p1));
      check($sformatf("vec%0d p2_held", i), 32'(p2_held), 32'(vecs[i].p2));
    end

    // Glitchy 0x1A never stays stable long enough to be accepted.
    evq.delete();
    repeat (6) begin
      keycode = 8'h1A;
      tick(7);
      keycode = 8'h00;
      tick(3);
    end
    tick(20);
    check("glitch n_evt", 32'(evq.size()), 32'd0);
    check("glitch p1_held", 32'(p1_held), 32'd0);

    // Overflow: six accepted changes with the consumer stalled.
    evt_if.evt_ready = 1'b0;
    evq.delete();
    repeat (3) begin
      keycode = 8'h07;
      tick(20);
      keycode = 8'h00;
      tick(20);
    end
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf valid", 32'(evt_if.evt_valid), 32'd1);
    check("ovf head", 32'(head()), 32'(5'b01001));
    evt_if.evt_ready = 1'b1;
    tick(10);
    check("ovf drained", 32'(evq.size()), 32'd4);
    check("ovf ev0", 32'(evq[0]), 32'(5'b01001));
    check("ovf ev1", 32'(evq[1]), 32'(5'b00001));
    check("ovf ev2", 32'(evq[2]), 32'(5'b01001));
    check("ovf ev3", 32'(evq[3]), 32'(5'b00001));
    check("ovf sticky", 32'(overflow), 32'd1);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("reset2");

    // Hold counter and saturation.
    evq.delete();
    keycode = 8'h09;
    tick(25);
    check("hold start", 32'(hold_frames), 32'd0);
    check("hold p1_held", 32'(p1_held), 32'(5'b10000));
    frame_ticks(10);
    check("hold 10", 32'(hold_frames), 32'd10);
    frame_ticks(300);
    check("hold sat", 32'(hold_frames), 32'd255);
    tick(5);
`ifdef KEY_REPEAT_EN
    exp_hold_events = 32;
`else
    exp_hold_events = 1;
`endif
    check("hold n_evt", 32'(evq.size()), 32'(exp_hold_events));
    keycode = 8'h00;
    tick(25);
    check("hold cleared", 32'(hold_frames), 32'd0);
    check("hold p1 clear", 32'(p1_held), 32'd0);

    // Reset while in the release-emit state, then re-detect the held key.
    evt_if.evt_ready = 1'b0;
    keycode = 8'h09;
    tick(16);
    check("mid pre-valid", 32'(evt_if.evt_valid), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("mid reset");
    tick(17);
    check("mid valid@16", 32'(evt_if.evt_valid), 32'd0);
    tick(1);
    check("mid valid@17", 32'(evt_if.evt_valid), 32'd1);
    check("mid head", 32'(head()), 32'(5'b01100));
    check("mid p1_held", 32'(p1_held), 32'(5'b10000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
